// File: rtl/tl_rx_vc_pkg.sv
// Shared definitions for the receive VC write sequencer and buffer control.
// Status encodings are consumed directly by buffer control.
package tl_rx_vc_pkg;

    typedef logic [1:0] w_status_t;

    localparam w_status_t ERROR_EVALUATE = 2'b00;
    localparam w_status_t HDR_RCV        = 2'b01;
    localparam w_status_t DATA_RCV       = 2'b10;
    localparam w_status_t ERROR_CHK      = 2'b11;

    localparam int ERR_TIMEOUT = 16;

endpackage

// File: rtl/tl_rx_vc_write_ctrl_if.sv
// Bundle between DLL/error checker/buffer control and the VC write sequencer.
// master: surrounding logic; slave: the write sequencer.
interface tl_rx_vc_write_ctrl_if #(
    parameter int HDR_PTR_SIZE  = 8,
    parameter int DATA_PTR_SIZE = 11
);
    logic                     i_dll_valid;
    logic                     i_dll_sop;
    logic                     i_dll_eop;
    logic                     i_dll_has_data;
    logic                     i_dll_td;
    logic                     i_err_valid;
    logic                     i_err_flag;
    logic                     i_hdr_full;
    logic                     i_data_full;
    logic                     i_w_hdr_inc;
    logic                     i_w_data_en;
    logic                     i_w_data_ptr_ld;
    logic [1:0]               o_w_status;
    logic                     o_w_valid;
    logic                     o_hdr_write_flag;
    logic                     o_digest_cycle_flag;
    logic                     o_w_data_transaction;
    logic [HDR_PTR_SIZE-1:0]  o_w_hdr_ptr;
    logic [DATA_PTR_SIZE-1:0] o_w_data_ptr;
    logic [DATA_PTR_SIZE-1:0] o_w_data_cntr;
    logic                     o_tlp_drop;

    modport master (
        output i_dll_valid, i_dll_sop, i_dll_eop, i_dll_has_data, i_dll_td,
        output i_err_valid, i_err_flag, i_hdr_full, i_data_full,
        output i_w_hdr_inc, i_w_data_en, i_w_data_ptr_ld,
        input  o_w_status, o_w_valid, o_hdr_write_flag, o_digest_cycle_flag,
        input  o_w_data_transaction, o_w_hdr_ptr, o_w_data_ptr,
        input  o_w_data_cntr, o_tlp_drop
    );

    modport slave (
        input  i_dll_valid, i_dll_sop, i_dll_eop, i_dll_has_data, i_dll_td,
        input  i_err_valid, i_err_flag, i_hdr_full, i_data_full,
        input  i_w_hdr_inc, i_w_data_en, i_w_data_ptr_ld,
        output o_w_status, o_w_valid, o_hdr_write_flag, o_digest_cycle_flag,
        output o_w_data_transaction, o_w_hdr_ptr, o_w_data_ptr,
        output o_w_data_cntr, o_tlp_drop
    );

endinterface

// File: rtl/tl_rx_vc_write_ctrl_w_ptr_unit.sv
// Committed header/data write pointers and speculative data counter,
// with commit and rollback of the counter.
module tl_rx_vc_w_ptr_unit #(
    parameter int HDR_PTR_SIZE  = 8,
    parameter int DATA_PTR_SIZE = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_inc,
    input  logic                     hdr_inc,
    input  logic                     ptr_ld,
    input  logic                     rollback,
    output logic [HDR_PTR_SIZE-1:0]  hdr_ptr,
    output logic [DATA_PTR_SIZE-1:0] data_ptr,
    output logic [DATA_PTR_SIZE-1:0] data_cntr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_ptr   <= '0;
            data_ptr  <= '0;
            data_cntr <= '0;
        end else begin
            if (hdr_inc)
                hdr_ptr <= hdr_ptr + 1'b1;
            if (ptr_ld)
                data_ptr <= data_cntr;
            if (rollback)
                data_cntr <= data_ptr;
            else if (data_inc)
                data_cntr <= data_cntr + 1'b1;
        end
    end

endmodule

// File: rtl/tl_rx_vc_write_ctrl.sv
// Write-side sequencer for one receive VC (status FSM and buffer strobes).
// Optional TL_RX_VC_ERR_TIMEOUT_EN: drop a TLP whose error verdict never arrives.
module tl_rx_vc_write_ctrl
    import tl_rx_vc_pkg::*;
#(
    parameter int HDR_PTR_SIZE  = 8,
    parameter int DATA_PTR_SIZE = 11
) (
    input  logic                 i_clk,
    input  logic                 i_n_rst,
    tl_rx_vc_write_ctrl_if.slave bus
);

    w_status_t state, state_nxt;
    logic      has_data_q, td_q, ovf;
    logic      w_valid_q, drop_q;
    logic      sop, go_eval, accept_nxt, timeout;
    logic      hdr_write, digest;

    assign sop        = bus.i_dll_valid & bus.i_dll_sop;
    assign accept_nxt = bus.i_err_valid & ~bus.i_err_flag & ~ovf;
    assign go_eval    = (state == ERROR_CHK) & (bus.i_err_valid | timeout);

`ifdef TL_RX_VC_ERR_TIMEOUT_EN
    logic [3:0] tmo_cnt;

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst)
            tmo_cnt <= '0;
        else if (state == ERROR_CHK)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    assign timeout = (state == ERROR_CHK) &
                     (tmo_cnt == 4'(ERR_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst)
            state <= HDR_RCV;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HDR_RCV:
                if (sop)
                    state_nxt = bus.i_dll_eop ? ERROR_CHK : DATA_RCV;
            DATA_RCV:
                if (bus.i_dll_valid & (bus.i_dll_eop | bus.i_dll_sop))
                    state_nxt = ERROR_CHK;
            ERROR_CHK:
                if (go_eval)
                    state_nxt = ERROR_EVALUATE;
            default:
                state_nxt = HDR_RCV;
        endcase
    end

    always_comb begin
        hdr_write = 1'b0;
        digest    = 1'b0;
        unique case (1'b1)
            (state == HDR_RCV):
                hdr_write = sop;
            (state == DATA_RCV):
                digest = bus.i_dll_valid & bus.i_dll_eop & td_q;
            default: ;
        endcase
    end

    // An SOP inside DATA_RCV truncates the current TLP, so it is marked bad.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            has_data_q <= 1'b0;
            td_q       <= 1'b0;
            ovf        <= 1'b0;
            w_valid_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            w_valid_q <= go_eval & accept_nxt;
            drop_q    <= go_eval & ~accept_nxt;
            unique case (state)
                HDR_RCV:
                    if (sop) begin
                        has_data_q <= bus.i_dll_has_data;
                        td_q       <= bus.i_dll_td;
                        ovf        <= bus.i_hdr_full;
                    end
                DATA_RCV:
                    if (bus.i_dll_valid &
                        (bus.i_dll_sop | (has_data_q & bus.i_data_full)))
                        ovf <= 1'b1;
                ERROR_CHK: ;
                default: begin
                    has_data_q <= 1'b0;
                    td_q       <= 1'b0;
                    ovf        <= 1'b0;
                end
            endcase
        end
    end

    tl_rx_vc_w_ptr_unit #(
        .HDR_PTR_SIZE  (HDR_PTR_SIZE),
        .DATA_PTR_SIZE (DATA_PTR_SIZE)
    ) u_ptr (
        .clk       (i_clk),
        .rst_n     (i_n_rst),
        .data_inc  ((state == DATA_RCV) & bus.i_w_data_en),
        .hdr_inc   ((state == ERROR_EVALUATE) & bus.i_w_hdr_inc),
        .ptr_ld    ((state == ERROR_EVALUATE) & bus.i_w_data_ptr_ld),
        .rollback  ((state == ERROR_EVALUATE) & ~w_valid_q),
        .hdr_ptr   (bus.o_w_hdr_ptr),
        .data_ptr  (bus.o_w_data_ptr),
        .data_cntr (bus.o_w_data_cntr)
    );

    assign bus.o_w_status           = state;
    assign bus.o_w_valid            = w_valid_q;
    assign bus.o_tlp_drop           = drop_q;
    assign bus.o_w_data_transaction = has_data_q;
    assign bus.o_hdr_write_flag     = hdr_write;
    assign bus.o_digest_cycle_flag  = digest;

endmodule

// File: tb/tb_tl_rx_vc_write_ctrl.sv
// Directed bench for tl_rx_vc_write_ctrl; timeout expectations follow
// TL_RX_VC_ERR_TIMEOUT_EN.
module tb_tl_rx_vc_write_ctrl;

    logic i_clk   = 1'b0;
    logic i_n_rst = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 i_clk = ~i_clk;

    tl_rx_vc_write_ctrl_if #(.HDR_PTR_SIZE(8), .DATA_PTR_SIZE(11)) bus();

    tl_rx_vc_write_ctrl #(.HDR_PTR_SIZE(8), .DATA_PTR_SIZE(11)) dut (
        .i_clk   (i_clk),
        .i_n_rst (i_n_rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_dll_valid     = 1'b0;
        bus.i_dll_sop       = 1'b0;
        bus.i_dll_eop       = 1'b0;
        bus.i_dll_has_data  = 1'b0;
        bus.i_dll_td        = 1'b0;
        bus.i_err_valid     = 1'b0;
        bus.i_err_flag      = 1'b0;
        bus.i_hdr_full      = 1'b0;
        bus.i_data_full     = 1'b0;
        bus.i_w_hdr_inc     = 1'b0;
        bus.i_w_data_en     = 1'b0;
        bus.i_w_data_ptr_ld = 1'b0;
    endtask

    task automatic do_reset();
        i_n_rst = 1'b0;
        clear_in();
        #7;
        i_n_rst = 1'b1;
        tick();
    endtask

    // SOP beat, ndata payload beats (beat full_at hits data_full), optional digest beat
    task automatic send_tlp(input int ndata, input bit td, input int full_at);
        bus.i_dll_valid    = 1'b1;
        bus.i_dll_sop      = 1'b1;
        bus.i_dll_has_data = 1'b1;
        bus.i_dll_td       = td;
        #1;
        check("sop_hdr_write", 32'(bus.o_hdr_write_flag), 1);
        tick();
        clear_in();
        for (int i = 1; i <= ndata; i++) begin
            bus.i_dll_valid = 1'b1;
            bus.i_w_data_en = 1'b1;
            bus.i_data_full = (i == full_at);
            bus.i_dll_eop   = !td && (i == ndata);
            if (ndata <= 8) begin
                #1;
                check("data_digest", 32'(bus.o_digest_cycle_flag), 0);
            end
            tick();
        end
        clear_in();
        if (td) begin
            bus.i_dll_valid = 1'b1;
            bus.i_dll_eop   = 1'b1;
            #1;
            check("eop_digest", 32'(bus.o_digest_cycle_flag), 1);
            tick();
            clear_in();
        end
    endtask

    task automatic finish_tlp(input bit err, input bit acc);
        check("chk_status", 32'(bus.o_w_status), 3);
        bus.i_err_valid = 1'b1;
        bus.i_err_flag  = err;
        tick();
        check("eval_status", 32'(bus.o_w_status), 0);
        check("eval_valid", 32'(bus.o_w_valid), 32'(acc));
        check("eval_drop", 32'(bus.o_tlp_drop), 32'(!acc));
        clear_in();
        bus.i_w_hdr_inc     = acc;
        bus.i_w_data_ptr_ld = acc;
        tick();
        clear_in();
        check("idle_status", 32'(bus.o_w_status), 1);
        check("idle_valid", 32'(bus.o_w_valid), 0);
        check("idle_drop", 32'(bus.o_tlp_drop), 0);
    endtask

    initial begin
        clear_in();
        do_reset();
        check("rst_status", 32'(bus.o_w_status), 1);
        check("rst_hdr_ptr", 32'(bus.o_w_hdr_ptr), 0);
        check("rst_data_ptr", 32'(bus.o_w_data_ptr), 0);
        check("rst_cntr", 32'(bus.o_w_data_cntr), 0);
        check("rst_valid", 32'(bus.o_w_valid), 0);
        check("rst_drop", 32'(bus.o_tlp_drop), 0);
        check("rst_hdr_write", 32'(bus.o_hdr_write_flag), 0);

        // header-only TLP, accepted
        bus.i_dll_valid = 1'b1;
        bus.i_dll_sop   = 1'b1;
        bus.i_dll_eop   = 1'b1;
        #1;
        check("ho_hdr_write", 32'(bus.o_hdr_write_flag), 1);
        tick();
        clear_in();
        check("ho_no_data", 32'(bus.o_w_data_transaction), 0);
        finish_tlp(1'b0, 1'b1);
        check("ho_hdr_ptr", 32'(bus.o_w_hdr_ptr), 1);
        check("ho_data_ptr", 32'(bus.o_w_data_ptr), 0);
        check("ho_cntr", 32'(bus.o_w_data_cntr), 0);

        // payload + digest, accepted
        do_reset();
        send_tlp(3, 1'b1, 0);
        check("pl_cntr", 32'(bus.o_w_data_cntr), 3);
        check("pl_data_tr", 32'(bus.o_w_data_transaction), 1);
        check("pl_ptr_before", 32'(bus.o_w_data_ptr), 0);
        finish_tlp(1'b0, 1'b1);
        check("pl_data_ptr", 32'(bus.o_w_data_ptr), 3);
        check("pl_cntr_after", 32'(bus.o_w_data_cntr), 3);
        check("pl_hdr_ptr", 32'(bus.o_w_hdr_ptr), 1);
        check("pl_data_tr_end", 32'(bus.o_w_data_transaction), 0);

        // same TLP, error flagged -> rollback
        do_reset();
        send_tlp(3, 1'b1, 0);
        check("er_cntr", 32'(bus.o_w_data_cntr), 3);
        finish_tlp(1'b1, 1'b0);
        check("er_cntr_rb", 32'(bus.o_w_data_cntr), 0);
        check("er_data_ptr", 32'(bus.o_w_data_ptr), 0);
        check("er_hdr_ptr", 32'(bus.o_w_hdr_ptr), 0);

        // pointer wrap at 11 bits
        do_reset();
        send_tlp(2046, 1'b0, 0);
        finish_tlp(1'b0, 1'b1);
        check("wr_ptr_2046", 32'(bus.o_w_data_ptr), 2046);
        check("wr_cntr_2046", 32'(bus.o_w_data_cntr), 2046);
        send_tlp(3, 1'b0, 0);
        check("wr_cntr_wrap", 32'(bus.o_w_data_cntr), 1);
        finish_tlp(1'b0, 1'b1);
        check("wr_ptr_wrap", 32'(bus.o_w_data_ptr), 1);
        check("wr_hdr_ptr", 32'(bus.o_w_hdr_ptr), 2);

        // data_full on 2nd payload beat
        do_reset();
        send_tlp(3, 1'b0, 2);
        finish_tlp(1'b0, 1'b0);
        check("df_cntr_rb", 32'(bus.o_w_data_cntr), 0);
        check("df_data_ptr", 32'(bus.o_w_data_ptr), 0);

        // hdr_full at SOP of a header-only TLP
        do_reset();
        bus.i_dll_valid = 1'b1;
        bus.i_dll_sop   = 1'b1;
        bus.i_dll_eop   = 1'b1;
        bus.i_hdr_full  = 1'b1;
        tick();
        clear_in();
        finish_tlp(1'b0, 1'b0);

        // SOP while in DATA_RCV ends the TLP as overflowed
        do_reset();
        bus.i_dll_valid    = 1'b1;
        bus.i_dll_sop      = 1'b1;
        bus.i_dll_has_data = 1'b1;
        tick();
        clear_in();
        check("ss_status", 32'(bus.o_w_status), 2);
        bus.i_dll_valid = 1'b1;
        bus.i_w_data_en = 1'b1;
        tick();
        clear_in();
        bus.i_dll_valid = 1'b1;
        bus.i_dll_sop   = 1'b1;
        #1;
        check("ss_hdr_write", 32'(bus.o_hdr_write_flag), 0);
        tick();
        clear_in();
        finish_tlp(1'b0, 1'b0);
        check("ss_cntr_rb", 32'(bus.o_w_data_cntr), 0);

        // missing error verdict
        do_reset();
        bus.i_dll_valid = 1'b1;
        bus.i_dll_sop   = 1'b1;
        bus.i_dll_eop   = 1'b1;
        tick();
        clear_in();
        for (int i = 0; i < 15; i++)
            tick();
        check("to_wait_status", 32'(bus.o_w_status), 3);
        tick();
`ifdef TL_RX_VC_ERR_TIMEOUT_EN
        check("to_eval_status", 32'(bus.o_w_status), 0);
        check("to_drop", 32'(bus.o_tlp_drop), 1);
        check("to_valid", 32'(bus.o_w_valid), 0);
        tick();
        check("to_idle_status", 32'(bus.o_w_status), 1);
`else
        check("to_stuck_status", 32'(bus.o_w_status), 3);
        check("to_no_drop", 32'(bus.o_tlp_drop), 0);
        finish_tlp(1'b0, 1'b1);
`endif

        // async reset mid-TLP
        do_reset();
        bus.i_dll_valid    = 1'b1;
        bus.i_dll_sop      = 1'b1;
        bus.i_dll_has_data = 1'b1;
        tick();
        clear_in();
        bus.i_dll_valid = 1'b1;
        bus.i_w_data_en = 1'b1;
        tick();
        clear_in();
        check("ar_cntr_pre", 32'(bus.o_w_data_cntr), 1);
        #2;
        i_n_rst = 1'b0;
        #1;
        check("ar_status", 32'(bus.o_w_status), 1);
        check("ar_cntr", 32'(bus.o_w_data_cntr), 0);
        check("ar_data_tr", 32'(bus.o_w_data_transaction), 0);
        check("ar_drop", 32'(bus.o_tlp_drop), 0);
        #2;
        i_n_rst = 1'b1;
        tick();
        check("ar_drop_after", 32'(bus.o_tlp_drop), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
